// File: rtl/array_snapshot_streamer.sv
// Captures a decimated window of a packed sample array into a small snapshot FIFO and
// streams each stored snapshot out one element per valid/ready handshake.
module array_snapshot_streamer #(
    parameter int unsigned SIGNAL_WIDTH = 10,
    parameter int unsigned LEN          = 256,
    parameter int unsigned VIEW_START   = 0,
    parameter int unsigned VIEW_LEN     = 16,
    parameter int unsigned DECIM        = 1,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FRAME_W      = 16,
    localparam int unsigned ElemW       = (VIEW_LEN > 1) ? $clog2(VIEW_LEN) : 1,
    localparam int unsigned PtrW        = $clog2(DEPTH),
    localparam int unsigned FillW       = PtrW + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [LEN*SIGNAL_WIDTH-1:0]  signal_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SIGNAL_WIDTH-1:0]      out_data,
    output logic [ElemW-1:0]             out_elem,
    output logic [FRAME_W-1:0]           out_frame,
    output logic                         out_last,
    output logic [15:0]                  overflow_cnt,
    output logic [FillW-1:0]             fill_level
);

    localparam int unsigned DecW  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned SnapW = VIEW_LEN * SIGNAL_WIDTH;

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e               state_q, state_d;
    logic [DecW-1:0]      dec_q, dec_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FillW-1:0]     fill_q, fill_d;
    logic [ElemW-1:0]     elem_q, elem_d;
    logic [15:0]          ovf_q, ovf_d;

    logic [SnapW-1:0]     snap_mem_q [DEPTH];
    logic [FRAME_W-1:0]   tag_mem_q  [DEPTH];

    logic                 capture;
    logic                 xfer;
    logic                 last_xfer;
    logic                 space;
    logic                 store;
    logic [SnapW-1:0]     view;
    logic [SnapW-1:0]     rd_entry;
    logic                 unused_in;

    // Only the configured window is stored; the rest of the array is deliberately ignored.
    assign view      = signal_in[VIEW_START*SIGNAL_WIDTH +: SnapW];
    assign unused_in = ^signal_in;

    assign capture   = enable && (dec_q == DecW'(DECIM - 1));
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && out_last;
    // A full buffer still has room when the head entry retires on this same edge.
    assign space     = (fill_q < FillW'(DEPTH)) || last_xfer;
    assign store     = capture && space;

    always_comb begin
        dec_d    = dec_q;
        frame_d  = frame_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        elem_d   = elem_q;
        fill_d   = fill_q;
        ovf_d    = ovf_q;
        state_d  = state_q;

        if (enable) begin
            dec_d = (dec_q == DecW'(DECIM - 1)) ? '0 : dec_q + 1'b1;
        end

        // Frame tags advance on every capture so dropped snapshots leave visible gaps.
        if (capture) begin
            frame_d = frame_q + 1'b1;
        end

        if (store) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (xfer) begin
            if (out_last) begin
                elem_d   = '0;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                elem_d   = elem_q + 1'b1;
            end
        end

        case ({store, last_xfer})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase

        if (capture && !space && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (store) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (last_xfer && (fill_q == FillW'(1)) && !store) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            dec_q    <= '0;
            frame_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            elem_q   <= '0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            dec_q    <= dec_d;
            frame_q  <= frame_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            elem_q   <= elem_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the pointers and fill count.
    always_ff @(posedge clk) begin
        if (store && !rst) begin
            snap_mem_q[wr_ptr_q] <= view;
            tag_mem_q[wr_ptr_q]  <= frame_q;
        end
    end

    assign rd_entry     = snap_mem_q[rd_ptr_q];
    assign out_valid    = (state_q == StStream);
    assign out_last     = out_valid && (elem_q == ElemW'(VIEW_LEN - 1));
    assign out_data     = out_valid ? rd_entry[elem_q*SIGNAL_WIDTH +: SIGNAL_WIDTH] : '0;
    assign out_frame    = out_valid ? tag_mem_q[rd_ptr_q] : '0;
    assign out_elem     = elem_q;
    assign overflow_cnt = ovf_q;
    assign fill_level   = fill_q;

endmodule
